// File: rtl/pipe_stage_reg.sv
// Hazard-tracking pipeline register between two adjacent MIPS stages.
// Holds the register addresses, result code and Tnew, plus a saturating bubble counter.
module pipe_stage_reg #(
  parameter int unsigned AW   = 5,
  parameter int unsigned NRA  = 2,
  parameter int unsigned RESW = 3,
  parameter int unsigned TW   = 2,
  parameter int unsigned DEC  = 1,
  parameter int unsigned CW   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  input  logic [NRA*AW-1:0] ra_in,
  input  logic [AW-1:0]     wa_in,
  input  logic [RESW-1:0]   res_in,
  input  logic [TW-1:0]     tnew_in,
  output logic              valid,
  output logic [NRA*AW-1:0] ra_out,
  output logic [AW-1:0]     wa_out,
  output logic [RESW-1:0]   res_out,
  output logic [TW-1:0]     tnew_out,
  output logic              fwd_ready,
  output logic [CW-1:0]     bubble_cnt
);

  logic              valid_q, valid_d;
  logic [NRA*AW-1:0] ra_q, ra_d;
  logic [AW-1:0]     wa_q, wa_d;
  logic [RESW-1:0]   res_q, res_d;
  logic [TW-1:0]     tnew_q, tnew_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              bubble;
  logic [31:0]       tnew_ext;
  logic [TW-1:0]     tnew_dec;

  // An empty upstream slot is indistinguishable from a flush.
  assign bubble   = flush | (~stall & ~in_valid);
  assign tnew_ext = 32'(tnew_in);
  assign tnew_dec = (tnew_ext > DEC) ? TW'(tnew_ext - DEC) : '0;

  always_comb begin
    valid_d = valid_q;
    ra_d    = ra_q;
    wa_d    = wa_q;
    res_d   = res_q;
    tnew_d  = tnew_q;
    cnt_d   = cnt_q;
    if (bubble) begin
      valid_d = 1'b0;
      ra_d    = '0;
      wa_d    = '0;
      res_d   = '0;
      tnew_d  = '0;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (!stall) begin
      valid_d = 1'b1;
      ra_d    = ra_in;
      tnew_d  = tnew_dec;
      // A write to $0 never produces a forwardable result.
      if (wa_in == '0) begin
        wa_d  = '0;
        res_d = '0;
      end else begin
        wa_d  = wa_in;
        res_d = res_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ra_q    <= '0;
      wa_q    <= '0;
      res_q   <= '0;
      tnew_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ra_q    <= ra_d;
      wa_q    <= wa_d;
      res_q   <= res_d;
      tnew_q  <= tnew_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid      = valid_q;
  assign ra_out     = ra_q;
  assign wa_out     = wa_q;
  assign res_out    = res_q;
  assign tnew_out   = tnew_q;
  assign bubble_cnt = cnt_q;
  assign fwd_ready  = valid_q && (wa_q != '0) && (tnew_q == '0);

endmodule
